// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUTRAM configuration writer.
// State encoding and depth/width derivations live here.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_LUT_SIZE = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Counters need at least one bit even for a single group.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int lut_depth(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/lut_config_writer_if.sv
// Configuration word stream: valid/ready handshake.
// The writer is the slave; the word source is the master.
interface lut_config_writer_if #(
  parameter int W = 32
) ();
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;

  modport master (
    output cfg_data, cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data, cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/lut_cfg_addr_gen.sv
// LUT address / group counter with a one-hot group decoder.
// Address walks the full LUT depth before the group steps.
module lut_cfg_addr_gen
  import lut_cfg_pkg::*;
#(
  parameter int ZS = 6,
  parameter int NG = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [ZS-1:0] addr,
  output logic          last_addr,
  output logic          last_group,
  output logic [NG-1:0] group_oh
);

  localparam int GW = cnt_w(NG);

  logic [ZS-1:0] addr_q, addr_d;
  logic [GW-1:0] group_q, group_d;

  assign addr       = addr_q;
  assign last_addr  = addr_q == ZS'(lut_depth(ZS) - 1);
  assign last_group = group_q == GW'(NG - 1);

  always_comb begin
    group_oh = '0;
    for (int g = 0; g < NG; g++)
      group_oh[g] = (group_q == GW'(g));
  end

  // Group never steps past the last one: the load ends there.
  always_comb begin
    addr_d  = addr_q;
    group_d = group_q;
    if (clear) begin
      addr_d  = '0;
      group_d = '0;
    end else if (advance) begin
      if (last_addr) begin
        addr_d = '0;
        if (!last_group) group_d = group_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      group_q <= '0;
    end else begin
      addr_q  <= addr_d;
      group_q <= group_d;
    end
  end

endmodule

// File: rtl/lut_config_writer.sv
// Write-side controller for LUTRAM configurable-mux LUTs.
// One accepted word becomes one registered write pulse to one group.
module lut_config_writer
  import lut_cfg_pkg::*;
#(
  parameter int ZUMA_LUT_SIZE = DEF_LUT_SIZE,
  parameter int CONFIG_WIDTH  = 32,
  parameter int NUM_GROUPS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  lut_config_writer_if.slave       cfg,
  output logic [ZUMA_LUT_SIZE-1:0] lut_a,
  output logic [CONFIG_WIDTH-1:0]  lut_d,
  output logic [NUM_GROUPS-1:0]    lut_we,
  output logic                     busy,
  output logic                     done
);

  state_e state_q, state_d;

  logic [ZUMA_LUT_SIZE-1:0] lut_a_q, lut_a_d;
  logic [CONFIG_WIDTH-1:0]  lut_d_q, lut_d_d;
  logic [NUM_GROUPS-1:0]    lut_we_q, lut_we_d;
  logic                     done_q, done_d;

  logic                     clear, advance;
  logic [ZUMA_LUT_SIZE-1:0] addr;
  logic                     last_addr, last_group;
  logic [NUM_GROUPS-1:0]    group_oh;

  lut_cfg_addr_gen #(
    .ZS(ZUMA_LUT_SIZE),
    .NG(NUM_GROUPS)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .advance   (advance),
    .addr      (addr),
    .last_addr (last_addr),
    .last_group(last_group),
    .group_oh  (group_oh)
  );

  assign cfg.cfg_ready = (state_q == ST_ACCEPT);
  assign busy   = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
  assign done   = done_q;
  assign lut_a  = lut_a_q;
  assign lut_d  = lut_d_q;
  assign lut_we = lut_we_q;

  always_comb begin
    state_d  = state_q;
    lut_a_d  = lut_a_q;
    lut_d_d  = lut_d_q;
    lut_we_d = '0;
    done_d   = done_q;
    clear    = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_ACCEPT;
          clear   = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_ACCEPT: begin
        // Write pulse is launched from a flop: no comb path from cfg_valid.
        if (cfg.cfg_valid) begin
          lut_a_d  = addr;
          lut_d_d  = cfg.cfg_data;
          lut_we_d = group_oh;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        advance = 1'b1;
        if (last_addr && last_group) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lut_a_q  <= '0;
      lut_d_q  <= '0;
      lut_we_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lut_a_q  <= lut_a_d;
      lut_d_q  <= lut_d_d;
      lut_we_q <= lut_we_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_lut_config_writer.sv
// Randomized scoreboard bench for lut_config_writer.
// Small config: 2 groups of 4 LUTs, 64 entries deep.
module tb_lut_config_writer;

  localparam int ZS    = 6;
  localparam int CW    = 4;
  localparam int NG    = 2;
  localparam int DEPTH = 64;
  localparam int WORDS = DEPTH * NG;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [ZS-1:0] lut_a;
  logic [CW-1:0] lut_d;
  logic [NG-1:0] lut_we;
  logic busy, done;

  always #5 clk = ~clk;

  lut_config_writer_if #(.W(CW)) cfg ();

  lut_config_writer #(
    .ZUMA_LUT_SIZE(ZS),
    .CONFIG_WIDTH (CW),
    .NUM_GROUPS   (NG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .cfg   (cfg),
    .lut_a (lut_a),
    .lut_d (lut_d),
    .lut_we(lut_we),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [NG-1:0] we;
    logic [ZS-1:0] a;
    logic [CW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  logic [CW-1:0] shadow  [NG][DEPTH];
  logic [CW-1:0] exp_mem [NG][DEPTH];
  bit            written [NG][DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_we = 0;
  int last_we_cyc = 0;
  int done_rise_cyc = 0;
  int word_idx = 0;
  bit prev_we_any = 1'b0;
  bit prev_done = 1'b0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] pat(input int p, input int i);
    return (p == 0) ? CW'(i) : CW'(i * 7 + 3);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every write pulse must match the next expected write.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (done === 1'b1 && !prev_done) done_rise_cyc = cyc;
    prev_done = (done === 1'b1);
    if (|lut_we) begin
      n_we++;
      last_we_cyc = cyc;
      chk(!prev_we_any, "we_back_to_back", 1, 0);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_write", 32'(lut_we), 0);
      end else begin
        e = exp_q.pop_front();
        chk(lut_we === e.we, "lut_we", 32'(lut_we), 32'(e.we));
        chk(lut_a === e.a, "lut_a", 32'(lut_a), 32'(e.a));
        chk(lut_d === e.d, "lut_d", 32'(lut_d), 32'(e.d));
      end
      for (int g = 0; g < NG; g++)
        if (lut_we[g]) begin
          shadow[g][lut_a]  = lut_d;
          written[g][lut_a] = 1'b1;
        end
    end
    prev_we_any = |lut_we;
  end

  // Called at posedge+1 with the DUT in IDLE or DONE.
  task automatic begin_load();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    word_idx = 0;
    n_we = 0;
    for (int g = 0; g < NG; g++)
      for (int a = 0; a < DEPTH; a++) begin
        written[g][a] = 1'b0;
        exp_mem[g][a] = '0;
      end
    @(negedge clk);
    chk(done === 1'b0, "done_cleared", 32'(done), 0);
    chk(busy === 1'b1, "busy_after_start", 32'(busy), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int duty, input int p,
                      input int stop_at, input int spur_at);
    int guard;
    bit spur;
    wr_t e;
    guard = 0;
    spur = 1'b0;
    while (word_idx < stop_at && guard < 20000) begin
      cfg.cfg_valid = ($urandom_range(0, 99) < duty);
      cfg.cfg_data  = pat(p, word_idx);
      if (word_idx == spur_at && !spur) begin
        start = 1'b1;
        spur  = 1'b1;
      end
      @(negedge clk);
      if (cfg.cfg_valid && cfg.cfg_ready) begin
        e.we = NG'(1) << (word_idx / DEPTH);
        e.a  = ZS'(word_idx % DEPTH);
        e.d  = pat(p, word_idx);
        exp_mem[word_idx / DEPTH][word_idx % DEPTH] = e.d;
        exp_q.push_back(e);
        word_idx++;
      end
      @(posedge clk);
      #1 start = 1'b0;
      guard++;
    end
    cfg.cfg_valid = 1'b0;
    if (guard >= 20000) chk(1'b0, "feed_timeout", word_idx, stop_at);
  endtask

  task automatic finish_load();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk(done === 1'b1, "done_timeout", 32'(done), 1);
    chk(done_rise_cyc - last_we_cyc == 1, "done_latency",
        done_rise_cyc - last_we_cyc, 1);
    chk(n_we == WORDS, "write_count", n_we, WORDS);
    chk(busy === 1'b0, "busy_when_done", 32'(busy), 0);
    chk(exp_q.size() == 0, "pending_writes", exp_q.size(), 0);
    @(posedge clk);
    #1 cfg.cfg_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk(cfg.cfg_ready === 1'b0, "ready_after_done",
          32'(cfg.cfg_ready), 0);
    end
    for (int g = 0; g < NG; g++)
      for (int a = 0; a < DEPTH; a++)
        chk(written[g][a] && shadow[g][a] === exp_mem[g][a],
            "lut_contents", 32'(shadow[g][a]), 32'(exp_mem[g][a]));
    @(posedge clk);
    #1 cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = '0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk(cfg.cfg_ready === 1'b0, "rst_ready", 32'(cfg.cfg_ready), 0);
      chk(lut_we === '0, "rst_we", 32'(lut_we), 0);
      chk(busy === 1'b0, "rst_busy", 32'(busy), 0);
      chk(done === 1'b0, "rst_done", 32'(done), 0);
      chk(lut_a === '0, "rst_a", 32'(lut_a), 0);
      chk(lut_d === '0, "rst_d", 32'(lut_d), 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(cfg.cfg_ready === 1'b0, "idle_ready", 32'(cfg.cfg_ready), 0);
      chk(lut_we === '0, "idle_we", 32'(lut_we), 0);
      chk(busy === 1'b0, "idle_busy", 32'(busy), 0);
    end
    @(posedge clk);
    #1 cfg.cfg_valid = 1'b0;

    begin_load();
    feed(100, 0, WORDS, -1);
    finish_load();

    begin_load();
    feed(30, 0, WORDS, 10);
    finish_load();

    begin_load();
    feed(100, 1, 40, -1);
    cfg.cfg_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(lut_we === '0, "midrst_we", 32'(lut_we), 0);
    chk(busy === 1'b0, "midrst_busy", 32'(busy), 0);
    chk(cfg.cfg_ready === 1'b0, "midrst_ready", 32'(cfg.cfg_ready), 0);
    chk(exp_q.size() == 0, "midrst_pending", exp_q.size(), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cfg.cfg_valid = 1'b0;

    begin_load();
    feed(100, 1, WORDS, -1);
    finish_load();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_config_writer.md
Name: lut_config_writer

Overview:
- Write-side controller for the LUTRAM-based configurable-mux LUTs; drives their a/d/we write port.
- Accepts configuration words over a valid/ready stream.
- Writes each word across CONFIG_WIDTH LUTs of one group in parallel, one LUT address per word.
- Walks addresses 0..2**ZUMA_LUT_SIZE-1 for group 0, then group 1, and so on, until every group is loaded.

Parameters:
- ZUMA_LUT_SIZE, `ZUMA_LUT_SIZE (6): LUT input count. Depth per LUT is LUT_DEPTH = 2**ZUMA_LUT_SIZE.
- CONFIG_WIDTH, 32: number of LUTs written in parallel. Bit i of a word goes to LUT i of the selected group.
- NUM_GROUPS, 16: number of LUT groups. Each group has its own write enable.

Ports:
- clk  in  1: single clock. All logic is rising-edge.
- reset  in  1: synchronous, active-high.
- start  in  1: one-cycle pulse that begins a full load. Ignored unless in IDLE or DONE.
- cfg_data  in  CONFIG_WIDTH: configuration word.
- cfg_valid  in  1: cfg_data is valid.
- cfg_ready  out  1: block accepts a word this cycle.
- lut_a  out  ZUMA_LUT_SIZE: LUTRAM write address. The a port is 6 bits wide; upper bits are zero if ZUMA_LUT_SIZE < 6.
- lut_d  out  CONFIG_WIDTH: write data, one bit per LUT.
- lut_we  out  NUM_GROUPS: one-hot-or-zero group write enable.
- busy  out  1: load in progress.
- done  out  1: sticky completion flag.

Behaviour:
- Reset state, applied on the next edge with reset high: state=IDLE, addr=0, group=0, cfg_ready=0, lut_we=0, lut_a=0, lut_d=0, busy=0, done=0.
- Reset mid-load abandons the load. The LUTs keep any partially written contents. No lut_we is asserted in the cycle after reset.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - cfg_ready=0, busy=0.
  - start=1 -> ACCEPT, with addr=0, group=0, done cleared to 0.
- ACCEPT:
  - cfg_ready=1, busy=1.
  - On a handshake (cfg_valid & cfg_ready) at edge N: register lut_d=cfg_data and lut_a=addr, then -> WRITE.
  - No handshake: stay in ACCEPT, lut_we=0.
- WRITE:
  - Lasts exactly one cycle, starting at edge N.
  - lut_we[group]=1, all other bits 0. lut_a and lut_d are stable for the whole cycle.
  - cfg_ready=0.
  - At the exit edge the address advances:
    - addr==LUT_DEPTH-1: addr=0, group=group+1.
    - otherwise: addr=addr+1.
  - Exit: if addr==LUT_DEPTH-1 and group==NUM_GROUPS-1 -> DONE; else -> ACCEPT.
- DONE:
  - done=1, busy=0, cfg_ready=0.
  - start=1 -> ACCEPT with done cleared (same as from IDLE).
  - done stays high until the next start or reset.
- start while in ACCEPT or WRITE is ignored: no restart, counters unchanged.
- Latency: handshake at edge N -> write pulse in cycle N..N+1. Peak throughput is one word per 2 cycles.
- Total words per load = LUT_DEPTH*NUM_GROUPS (1024 at defaults). cfg_valid beyond the last word is never accepted.
- Stalls: cfg_valid may drop at any time; ACCEPT waits indefinitely.
- Counter widths:
  - addr is ZUMA_LUT_SIZE bits.
  - group is clog2(NUM_GROUPS) bits, minimum 1.
  - The increment never wraps past NUM_GROUPS-1 because the load terminates there.
- lut_we is registered directly from the state/group registers, with no combinational path from cfg_valid.

Decomposition:
- Shared header/package lut_cfg_pkg holds:
  - state encoding: IDLE=2'd0, ACCEPT=2'd1, WRITE=2'd2, DONE=2'd3;
  - the LUT_DEPTH derivation;
  - a clog2 function.
- One sub-module, lut_cfg_addr_gen:
  - addr/group counter with an advance input;
  - last-address output and a one-hot group decoder;
  - the FSM lives in the top module.

Test Plan:
- Reset then idle: hold reset 2 cycles, cfg_valid=1 -> cfg_ready=0, lut_we=0, busy=0, done=0 throughout.
- Full load at NUM_GROUPS=2, CONFIG_WIDTH=4, data = word index mod 16, cfg_valid always 1:
  - exactly 128 lut_we pulses;
  - pulses 0..63 on lut_we=2'b01 with lut_a=0..63, pulses 64..127 on lut_we=2'b10;
  - each lut_d = index mod 16;
  - done rises in the cycle after write 127;
  - the shadow LUT model matches the expected contents.
- Back-pressure: cfg_valid toggled randomly at 30% duty -> same write sequence and final contents as full load; one lut_we per accepted word, never two consecutive cycles.
- start during load: pulse start at word 10 -> no restart, word 11 written at lut_a=11.
- Reset mid-load at word 40:
  - cycle after reset: lut_we=0, busy=0;
  - new start -> first write at group 0, lut_a=0.
- Reload from DONE: start after done -> done drops next cycle, second full load completes with new data overwriting all 128 entries.
